seq_mag_cmp_ctrl: RTL and testbench
===================================

Name: seq_mag_cmp_ctrl

Overview:
- Multi-cycle magnitude comparator controller for wide unsigned operands.
- Sequences a single shared 2-bit comparator slice across the operands, MSB digit first, and stops at the first differing digit.
- Registered gt/eq/lt result with start/done handshake.
- Used where wide compares are infrequent and area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. N = WIDTH/2 digits.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request compare; accepted only when ready=1.
- abort  in  1  synchronous cancel of an in-flight compare.
- a  in  WIDTH  operand A, unsigned; sampled on accepted start.
- b  in  WIDTH  operand B, unsigned; sampled on accepted start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in CMP.
- done  out  1  one-cycle pulse; results valid from this cycle.
- a_gt_b  out  1  registered result, A > B.
- a_eq_b  out  1  registered result, A == B.
- a_lt_b  out  1  registered result, A < B.
- digits_used  out  $clog2(N+1)  number of digits examined in the last completed compare.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = IDLE, ready = 1, busy = 0, done = 0.
  - a_gt_b = a_eq_b = a_lt_b = 0, digits_used = 0.
  - Internal operand registers and digit index = 0.
- States: IDLE, CMP, DONE.
- IDLE: start=1 latches a/b into internal registers, sets idx = N-1, clears the result flags, and moves to CMP. Start is ignored outside IDLE.
- CMP: each cycle feeds digit idx of A and B (bits 2*idx+1 : 2*idx) to the slice.
  - Slice gt or lt: the matching flag is set, digits_used = N-idx, next state DONE.
  - Slice eq and idx == 0: a_eq_b = 1, digits_used = N, next state DONE.
  - Slice eq and idx > 0: idx decrements, stay in CMP.
- DONE: done = 1 for exactly one cycle, then IDLE. Flags and digits_used hold until the next accepted start.
- Exactly one flag is high after any completed compare.
- Latency from the start-accept edge:
  - done is high in cycle k+1, where k = number of digits examined.
  - Best case 2 cycles, worst case N+1.
- abort: in CMP, forces IDLE next cycle. No done pulse, flags stay cleared, digits_used unchanged. Ignored in IDLE and DONE.
- Start and abort together in IDLE: start wins; abort has no effect.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronous). No done pulse is produced.
- The compare is purely unsigned; there is no sign handling.

Decomposition:
- Shared package: state enum (IDLE, CMP, DONE) and a localparam function computing N and the index width from WIDTH.
- One sub-module, cmp_digit_2b: combinational 2-bit unsigned slice with outputs gt/eq/lt, instantiated once.
- The controller holds the FSM, operand registers, index counter and result registers.

Test Plan (WIDTH=8):
- Reset then idle: ready=1, busy=0, done never pulses, all flags 0.
- a=0xC3, b=0x43, start: top digit 11 vs 01 -> done in cycle 2, a_gt_b=1, digits_used=1.
- a=0x12, b=0x13, start: differs at digit 0 -> done in cycle 5, a_lt_b=1, digits_used=4.
- a=0x5A, b=0x5A, start: -> done in cycle 5, a_eq_b=1, digits_used=4. A start pulse during busy is ignored, with no second done.
- a=0x00, b=0x01, start; abort in cycle 2 -> IDLE in cycle 3, no done, flags 0, ready=1. A following start with a=0xFF, b=0x00 gives a_gt_b=1 in cycle 2.
- Async rst_n low in cycle 2 of the 0x12/0x13 compare -> immediate reset values, no done. A new compare afterwards runs normally.

Source files
------------

// File: rtl/seq_mag_cmp_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_mag_cmp_ctrl_pkg : shared FSM state type and sizing helpers. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package seq_mag_cmp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width);
    return width / 2;
  endfunction

  // A single-digit operand still needs a 1-bit index register.
  function automatic int idx_width(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mag_cmp_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_mag_cmp_ctrl_if : start/done handshake, operands and results. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface seq_mag_cmp_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int DW = $clog2(WIDTH / 2 + 1);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;
  logic [DW-1:0]    digits_used;

  modport master (
    output start, abort, a, b,
    input  ready, busy, done, a_gt_b, a_eq_b, a_lt_b, digits_used
  );

  modport slave (
    input  start, abort, a, b,
    output ready, busy, done, a_gt_b, a_eq_b, a_lt_b, digits_used
  );
endinterface
`default_nettype wire

// File: rtl/seq_mag_cmp_ctrl_cmp_digit_2b.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cmp_digit_2b : combinational 2-bit unsigned magnitude slice.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cmp_digit_2b (
  input  wire logic [1:0] i_a,
  input  wire logic [1:0] i_b,
  output logic            o_gt,
  output logic            o_eq,
  output logic            o_lt
);
  assign o_gt = (i_a > i_b);
  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a < i_b);
endmodule
`default_nettype wire

// File: rtl/seq_mag_cmp_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_mag_cmp_ctrl : MSB-first digit-serial unsigned comparator.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_mag_cmp_ctrl
  import seq_mag_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  seq_mag_cmp_ctrl_if.slave  bus
);
  localparam int N  = num_digits(WIDTH);
  localparam int IW = idx_width(WIDTH);
  localparam int DW = $clog2(N + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic [DW-1:0]    r_used;

  logic [1:0]       w_da;
  logic [1:0]       w_db;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;
  logic [DW-1:0]    w_used;

  assign w_da   = r_a[{r_idx, 1'b0} +: 2];
  assign w_db   = r_b[{r_idx, 1'b0} +: 2];
  assign w_used = DW'(N) - DW'(r_idx);

  cmp_digit_2b u_slice (
    .i_a  (w_da),
    .i_b  (w_db),
    .o_gt (w_gt),
    .o_eq (w_eq),
    .o_lt (w_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_used  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_idx   <= IW'(N - 1);
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CMP;
          end
        end
        ST_CMP: begin
          if (bus.abort) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (!w_eq || r_idx == '0) begin
            // First differing digit decides; all-equal resolves on digit 0.
            r_gt    <= w_gt;
            r_lt    <= w_lt;
            r_eq    <= w_eq;
            r_used  <= w_used;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.a_gt_b      = r_gt;
  assign bus.a_eq_b      = r_eq;
  assign bus.a_lt_b      = r_lt;
  assign bus.digits_used = r_used;
endmodule
`default_nettype wire

// File: tb/tb_seq_mag_cmp_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seq_mag_cmp_ctrl : directed + random bench with reference model|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_seq_mag_cmp_ctrl;
  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mag_cmp_ctrl_if #(.WIDTH(WIDTH)) u_if ();

  seq_mag_cmp_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int n_total   = 0;
  int n_pass    = 0;
  int last_used = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Digits examined = position of the first differing digit counted from the MSB side.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output int used, output logic gt, output logic eq,
                                output logic lt);
    int da, db;
    used = 0;
    for (int d = N - 1; d >= 0; d--) begin
      used++;
      da = (int'(a) >> (2 * d)) % 4;
      db = (int'(b) >> (2 * d)) % 4;
      if (da != db) break;
    end
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  endfunction

  task automatic do_compare(input string tag, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input bit poke, input bit with_abort);
    int   used;
    logic gt, eq, lt;
    int   seen  = 0;
    int   extra = 0;
    model(a, b, used, gt, eq, lt);
    @(posedge clk); #1;
    u_if.a = a; u_if.b = b; u_if.start = 1'b1; u_if.abort = with_abort;
    @(posedge clk); #1;
    u_if.start = 1'b0; u_if.abort = 1'b0;
    u_if.a = WIDTH'($urandom); u_if.b = WIDTH'($urandom);
    for (int cyc = 1; cyc <= N + 2 && seen == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, ".busy1"}, u_if.busy, 1);
        check({tag, ".ready1"}, u_if.ready, 0);
      end
      if (poke) u_if.start = (cyc == 1);
      if (u_if.done) seen = cyc;
    end
    u_if.start = 1'b0;
    check({tag, ".latency"}, seen, used + 1);
    check({tag, ".gt"}, u_if.a_gt_b, gt);
    check({tag, ".eq"}, u_if.a_eq_b, eq);
    check({tag, ".lt"}, u_if.a_lt_b, lt);
    check({tag, ".used"}, u_if.digits_used, used);
    check({tag, ".busy_done"}, u_if.busy, 0);
    @(negedge clk);
    check({tag, ".done_off"}, u_if.done, 0);
    check({tag, ".ready_after"}, u_if.ready, 1);
    check({tag, ".flag_hold"}, {u_if.a_gt_b, u_if.a_eq_b, u_if.a_lt_b}, {gt, eq, lt});
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        extra += int'(u_if.done);
      end
      check({tag, ".no_second_done"}, extra, 0);
    end
    last_used = used;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int idle_done = 0;
    u_if.start = 1'b0; u_if.abort = 1'b0; u_if.a = '0; u_if.b = '0;
    repeat (3) @(negedge clk);
    check("rst.ready", u_if.ready, 1);
    check("rst.busy", u_if.busy, 0);
    check("rst.done", u_if.done, 0);
    check("rst.flags", {u_if.a_gt_b, u_if.a_eq_b, u_if.a_lt_b}, 3'b000);
    check("rst.used", u_if.digits_used, 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      idle_done += int'(u_if.done);
    end
    check("idle.done", idle_done, 0);
    check("idle.ready", u_if.ready, 1);
    check("idle.busy", u_if.busy, 0);
    check("idle.flags", {u_if.a_gt_b, u_if.a_eq_b, u_if.a_lt_b}, 3'b000);

    do_compare("c3_43", 8'hC3, 8'h43, 1'b0, 1'b0);
    do_compare("12_13", 8'h12, 8'h13, 1'b0, 1'b0);
    do_compare("5a_5a", 8'h5A, 8'h5A, 1'b1, 1'b0);

    // Abort during the second CMP cycle.
    @(posedge clk); #1;
    u_if.a = 8'h00; u_if.b = 8'h01; u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    @(posedge clk); #1;
    check("abort.c2_done", u_if.done, 0);
    u_if.abort = 1'b1;
    @(posedge clk); #1;
    u_if.abort = 1'b0;
    check("abort.ready", u_if.ready, 1);
    check("abort.busy", u_if.busy, 0);
    check("abort.done", u_if.done, 0);
    check("abort.flags", {u_if.a_gt_b, u_if.a_eq_b, u_if.a_lt_b}, 3'b000);
    check("abort.used", u_if.digits_used, last_used);
    @(negedge clk);
    check("abort.done_later", u_if.done, 0);
    do_compare("ff_00", 8'hFF, 8'h00, 1'b0, 1'b0);
    do_compare("start_wins", 8'h30, 8'h31, 1'b0, 1'b1);

    // Asynchronous reset in cycle 2 of a compare.
    @(posedge clk); #1;
    u_if.a = 8'h12; u_if.b = 8'h13; u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst.ready", u_if.ready, 1);
    check("arst.busy", u_if.busy, 0);
    check("arst.done", u_if.done, 0);
    check("arst.flags", {u_if.a_gt_b, u_if.a_eq_b, u_if.a_lt_b}, 3'b000);
    check("arst.used", u_if.digits_used, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst.idle_done", u_if.done, 0);
    do_compare("post_rst", 8'h12, 8'h13, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = WIDTH'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      endcase
      do_compare($sformatf("rnd%0d", i), ra, rb, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
